biu_prefetch_unit: RTL and testbench

- Parametrised successor to the current fixed 8-bit queue and bus path.
- Owns its fetch pointer and forms the physical fetch address as (CS << SEG_SHIFT) + fetch IP.
- Issues byte reads on the external bus with a req/ack handshake and buffers fetched bytes in a DEPTH-entry prefetch queue.
- Presents an INSTR_BYTES-wide instruction window to the decoder, with variable-length consume and flush-on-branch.

---
 rtl/biu_pkg.sv | 37 +++
 rtl/prefetch_fifo.sv | 94 +++++++++
 rtl/biu_prefetch_unit.sv | 169 ++++++++++++++++
 tb/tb_biu_prefetch_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/biu_pkg.sv
// -----------------------------------------------------------------------------
// biu_pkg
// Shared types and helpers for the bus interface prefetch unit.
//   - biu_state_e : fetch sequencer states (IDLE, FETCH, DRAIN)
//   - phys_addr   : segment:offset to physical address translation
//   - BIU_*       : default widths used by the prefetch unit parameters
// -----------------------------------------------------------------------------
package biu_pkg;

  localparam int BIU_DATA_W    = 8;
  localparam int BIU_ADDR_W    = 20;
  localparam int BIU_SEG_SHIFT = 4;

  // IDLE : queue full, no request on the bus
  // FETCH: request outstanding, returned byte is kept
  // DRAIN: request outstanding after a flush, returned byte is thrown away
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } biu_state_e;

  // (segment << shift) + offset, truncated to 'width' bits (width <= 32).
  function automatic logic [31:0] phys_addr(
    input logic [15:0] segment,
    input logic [15:0] offset,
    input int          shift,
    input int          width
  );
    logic [63:0] sum;
    logic [63:0] mask;
    sum  = ({48'd0, segment} << shift) + {48'd0, offset};
    mask = (64'd1 << width) - 64'd1;
    return 32'(sum & mask);
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// -----------------------------------------------------------------------------
// prefetch_fifo
// Circular byte queue with one push per cycle and a multi-entry pop, plus a
// registered window of the oldest INSTR_BYTES entries.
//   clk, reset    : clock, asynchronous active-high reset
//   clear         : empty the queue (wins over push and pop)
//   push          : write push_data behind the current contents
//   pop_len       : entries removed from the head this cycle (0..INSTR_BYTES,
//                   caller guarantees pop_len <= level)
//   level         : registered occupancy
//   level_next    : occupancy after this cycle's clear/push/pop
//   window        : registered oldest entries, entry 0 in LSBs, zero past level
//   window_valid  : registered level >= INSTR_BYTES
// -----------------------------------------------------------------------------
module prefetch_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 6,
  parameter int INSTR_BYTES = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            push,
  input  logic [DATA_W-1:0]               push_data,
  input  logic [$clog2(INSTR_BYTES+1)-1:0] pop_len,
  output logic [$clog2(DEPTH+1)-1:0]      level,
  output logic [$clog2(DEPTH+1)-1:0]      level_next,
  output logic [INSTR_BYTES*DATA_W-1:0]   window,
  output logic                            window_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0]             mem [DEPTH];
  logic [PTR_W-1:0]              rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]              wr_ptr_reg, wr_ptr_next;
  logic [LVL_W-1:0]              level_reg;
  logic [INSTR_BYTES*DATA_W-1:0] window_reg, window_next;
  logic                          window_valid_reg;
  logic                          push_eff;

  // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [LVL_W-1:0] n);
    int s;
    s = int'(p) + int'(n);
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  assign push_eff    = push && !clear;
  assign rd_ptr_next = clear ? '0 : ptr_add(rd_ptr_reg, LVL_W'(pop_len));
  assign wr_ptr_next = clear ? '0 :
                       (push_eff ? ptr_add(wr_ptr_reg, LVL_W'(1)) : wr_ptr_reg);
  assign level_next  = clear ? '0 :
                       (level_reg + LVL_W'(push_eff) - LVL_W'(pop_len));

  // Window is built from the post-update queue; the byte being pushed this
  // cycle is not in mem yet, so it is forwarded straight from push_data.
  for (genvar gi = 0; gi < INSTR_BYTES; gi++) begin : g_window
    logic [PTR_W-1:0] idx;
    assign idx = ptr_add(rd_ptr_next, LVL_W'(gi));
    assign window_next[gi*DATA_W +: DATA_W] =
      (LVL_W'(gi) < level_next) ?
        ((push_eff && (idx == wr_ptr_reg)) ? push_data : mem[idx]) :
        '0;
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      level_reg        <= '0;
      window_reg       <= '0;
      window_valid_reg <= 1'b0;
    end else begin
      rd_ptr_reg       <= rd_ptr_next;
      wr_ptr_reg       <= wr_ptr_next;
      level_reg        <= level_next;
      window_reg       <= window_next;
      window_valid_reg <= (level_next >= LVL_W'(INSTR_BYTES));
    end
  end

  assign level        = level_reg;
  assign window       = window_reg;
  assign window_valid = window_valid_reg;

endmodule

// File: rtl/biu_prefetch_unit.sv
// -----------------------------------------------------------------------------
// biu_prefetch_unit
// Instruction prefetcher: fetches bytes from (cs_base << SEG_SHIFT) + fetch_ip
// over a req/ack bus into a DEPTH-entry queue and exposes the oldest
// INSTR_BYTES entries to the decoder.
//   clk, reset        : clock, asynchronous active-high reset
//   cs_base, ip_load  : code segment, restart IP used on flush
//   flush             : empty the queue and restart fetching at ip_load
//   bus_req/bus_addr  : read request, address held while bus_req=1
//   bus_ack/bus_data  : read completion with data
//   instr/instr_valid : oldest entries (entry 0 in LSBs), level >= INSTR_BYTES
//   consume/consume_len : pop 1..INSTR_BYTES entries when instr_valid=1
//   level, fetch_ip   : queue occupancy, IP of the next byte to fetch
// Optional build macro BIU_FLUSH_COUNT_EN adds flush_count and discard_count,
// saturating 16-bit counts of flush events and of bus bytes thrown away.
// -----------------------------------------------------------------------------
module biu_prefetch_unit
  import biu_pkg::*;
#(
  parameter int DATA_W      = BIU_DATA_W,
  parameter int DEPTH       = 6,           // 2..32
  parameter int INSTR_BYTES = 4,           // <= DEPTH
  parameter int ADDR_W      = BIU_ADDR_W,  // <= 32
  parameter int SEG_SHIFT   = BIU_SEG_SHIFT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [15:0]                      cs_base,
  input  logic [15:0]                      ip_load,
  input  logic                             flush,
  output logic                             bus_req,
  output logic [ADDR_W-1:0]                bus_addr,
  input  logic                             bus_ack,
  input  logic [DATA_W-1:0]                bus_data,
  output logic [INSTR_BYTES*DATA_W-1:0]    instr,
  output logic                             instr_valid,
  input  logic                             consume,
  input  logic [$clog2(INSTR_BYTES+1)-1:0] consume_len,
  output logic [$clog2(DEPTH+1)-1:0]       level,
  output logic [15:0]                      fetch_ip
`ifdef BIU_FLUSH_COUNT_EN
  ,
  output logic [15:0]                      flush_count,
  output logic [15:0]                      discard_count
`endif
);

  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int LEN_W = $clog2(INSTR_BYTES+1);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LEN_W-1:0] IB_L    = LEN_W'(INSTR_BYTES);

  biu_state_e        state_reg, state_next;
  logic [15:0]       fetch_ip_reg, fetch_ip_next;
  logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
  logic              load_addr;
  logic              push;
  logic              pop_ok;
  logic [LEN_W-1:0]  pop_len;
  logic [LVL_W-1:0]  level_next;

  // Only a byte returned in FETCH belongs to the current stream.
  assign push    = (state_reg == FETCH) && bus_ack && !flush;
  assign pop_ok  = consume && instr_valid && !flush &&
                   (consume_len != '0) && (consume_len <= IB_L);
  assign pop_len = pop_ok ? consume_len : '0;

  assign fetch_ip_next = flush ? ip_load :
                         (push ? fetch_ip_reg + 16'd1 : fetch_ip_reg);

  // Next request address always follows the post-update fetch IP, so a
  // flush in the same cycle retargets the new request at ip_load.
  assign bus_addr_next = ADDR_W'(phys_addr(cs_base, fetch_ip_next,
                                           SEG_SHIFT, ADDR_W));

  prefetch_fifo #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .clear        (flush),
    .push         (push),
    .push_data    (bus_data),
    .pop_len      (pop_len),
    .level        (level),
    .level_next   (level_next),
    .window       (instr),
    .window_valid (instr_valid)
  );

  always_comb begin
    state_next = state_reg;
    load_addr  = 1'b0;
    case (state_reg)
      IDLE: begin
        // A flush empties the queue, so it also lands here.
        if (level_next < DEPTH_L) begin
          state_next = FETCH;
          load_addr  = 1'b1;
        end
      end
      FETCH: begin
        if (bus_ack) begin
          if (level_next < DEPTH_L) begin
            state_next = FETCH;
            load_addr  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (flush) begin
          // The request cannot be withdrawn; wait for it and drop its data.
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus_ack) begin
          state_next = FETCH;
          load_addr  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      fetch_ip_reg <= 16'd0;
      bus_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_ip_reg <= fetch_ip_next;
      if (load_addr) bus_addr_reg <= bus_addr_next;
    end
  end

  assign bus_req  = (state_reg != IDLE);
  assign bus_addr = bus_addr_reg;
  assign fetch_ip = fetch_ip_reg;

`ifdef BIU_FLUSH_COUNT_EN
  logic [15:0] flush_count_reg;
  logic [15:0] discard_count_reg;
  logic        discard_evt;

  // Bus bytes lost to a flush: returned together with the flush, or while
  // draining a request issued before it.
  assign discard_evt = bus_ack &&
                       (((state_reg == FETCH) && flush) || (state_reg == DRAIN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_count_reg   <= 16'd0;
      discard_count_reg <= 16'd0;
    end else begin
      if (flush && (flush_count_reg != 16'hFFFF))
        flush_count_reg <= flush_count_reg + 16'd1;
      if (discard_evt && (discard_count_reg != 16'hFFFF))
        discard_count_reg <= discard_count_reg + 16'd1;
    end
  end

  assign flush_count   = flush_count_reg;
  assign discard_count = discard_count_reg;
`endif

endmodule

// File: tb/tb_biu_prefetch_unit.sv
module tb_biu_prefetch_unit;

  localparam int DEPTH = 6;
  localparam int IB    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cs_base = 16'd0;
  logic [15:0] ip_load = 16'd0;
  logic        flush = 1'b0;
  logic        bus_req;
  logic [19:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic [7:0]  bus_data = 8'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        consume = 1'b0;
  logic [2:0]  consume_len = 3'd0;
  logic [2:0]  level;
  logic [15:0] fetch_ip;
`ifdef BIU_FLUSH_COUNT_EN
  logic [15:0] flush_count;
  logic [15:0] discard_count;
`endif

  always #5 clk = ~clk;

  biu_prefetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .cs_base     (cs_base),
    .ip_load     (ip_load),
    .flush       (flush),
    .bus_req     (bus_req),
    .bus_addr    (bus_addr),
    .bus_ack     (bus_ack),
    .bus_data    (bus_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .consume     (consume),
    .consume_len (consume_len),
    .level       (level),
    .fetch_ip    (fetch_ip)
`ifdef BIU_FLUSH_COUNT_EN
    ,
    .flush_count   (flush_count),
    .discard_count (discard_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (request-level view) ----------------
  typedef struct {
    logic        req;
    logic [19:0] addr;
    int          lvl;
    logic        valid;
    logic [31:0] win;
    logic [15:0] ip;
    logic [15:0] fc;
    logic [15:0] dc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];          // bytes in fetch order
  int         m_ip    = 0;
  bit         m_act   = 0;    // a bus request is outstanding
  bit         m_stale = 0;    // outstanding request predates a flush
  int         m_addr  = 0;
  int         m_fc    = 0;
  int         m_dc    = 0;
  int         txn     = 0;

  // Drive one cycle of inputs, advance the model across the coming edge,
  // queue the expected post-edge outputs, then move to the next negedge.
  task automatic step(input bit f, input logic [15:0] ipl, input bit ack,
                      input bit c, input int len, input logic [15:0] cs);
    logic [7:0] d;
    bit         valid_prev;
    exp_t       e;
    d           = 8'($urandom);
    flush       = f;
    ip_load     = ipl;
    bus_ack     = ack;
    bus_data    = d;
    consume     = c;
    consume_len = 3'(len);
    cs_base     = cs;

    valid_prev = (mq.size() >= IB);
    if (m_act && ack) begin
      txn++;
      if (f || m_stale) begin
        if (m_dc != 16'hFFFF) m_dc++;
        $display("txn %0d addr=%05h data=%02h dropped", txn, m_addr, d);
      end else begin
        mq.push_back(d);
        m_ip = (m_ip + 1) & 16'hFFFF;
        $display("txn %0d addr=%05h data=%02h kept level=%0d", txn, m_addr, d, mq.size());
      end
    end
    if (!f && c && valid_prev && len >= 1 && len <= IB)
      repeat (len) void'(mq.pop_front());
    if (f) begin
      mq.delete();
      m_ip = int'(ipl);
      if (m_fc != 16'hFFFF) m_fc++;
    end
    if (m_act && !ack) begin
      if (f) m_stale = 1;
    end else if (mq.size() < DEPTH) begin
      m_act   = 1;
      m_stale = 0;
      m_addr  = ((int'(cs) << 4) + m_ip) & 20'hFFFFF;
    end else begin
      m_act = 0;
    end

    e.req   = m_act;
    e.addr  = 20'(m_addr);
    e.lvl   = mq.size();
    e.valid = (mq.size() >= IB);
    e.win   = '0;
    for (int i = 0; i < IB; i++)
      if (i < mq.size()) e.win[i*8 +: 8] = mq[i];
    e.ip = 16'(m_ip);
    e.fc = 16'(m_fc);
    e.dc = 16'(m_dc);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("bus_req", 64'(bus_req), 64'(mon_e.req));
      if (mon_e.req) chk("bus_addr", 64'(bus_addr), 64'(mon_e.addr));
      chk("level", 64'(level), 64'(mon_e.lvl));
      chk("instr_valid", 64'(instr_valid), 64'(mon_e.valid));
      chk("instr", 64'(instr), 64'(mon_e.win));
      chk("fetch_ip", 64'(fetch_ip), 64'(mon_e.ip));
`ifdef BIU_FLUSH_COUNT_EN
      chk("flush_count", 64'(flush_count), 64'(mon_e.fc));
      chk("discard_count", 64'(discard_count), 64'(mon_e.dc));
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] cs;
    logic [15:0] ipl;
    repeat (3) @(negedge clk);
    chk("rst bus_req", 64'(bus_req), 64'd0);
    chk("rst bus_addr", 64'(bus_addr), 64'd0);
    chk("rst level", 64'(level), 64'd0);
    chk("rst instr", 64'(instr), 64'd0);
    chk("rst instr_valid", 64'(instr_valid), 64'd0);
    chk("rst fetch_ip", 64'(fetch_ip), 64'd0);
`ifdef BIU_FLUSH_COUNT_EN
    chk("rst flush_count", 64'(flush_count), 64'd0);
    chk("rst discard_count", 64'(discard_count), 64'd0);
`endif
    reset = 1'b0;

    // Flush to 0x0010 in segment 0x1000, then fill with an ack every cycle.
    step(1, 16'h0010, 0, 0, 0, 16'h1000);
    chk("t1 first addr", 64'(bus_addr), 64'h10010);
    repeat (12) step(0, 0, 1, 0, 0, 16'h1000);
    chk("t2 full level", 64'(level), 64'd6);
    chk("t2 full fetch_ip", 64'(fetch_ip), 64'h0016);
    chk("t2 full no req", 64'(bus_req), 64'd0);
    step(0, 0, 0, 1, 3, 16'h1000);
    chk("t2 level after pop", 64'(level), 64'd3);
    chk("t2 req again", 64'(bus_req), 64'd1);
    chk("t2 req addr", 64'(bus_addr), 64'h10016);

    // Flush while a request is pending; ack held off for 3 cycles.
    step(1, 16'h0200, 0, 0, 0, 16'h1000);
    step(0, 0, 0, 0, 0, 16'h1000);
    step(0, 0, 0, 0, 0, 16'h1000);
    chk("t3 drain addr held", 64'(bus_addr), 64'h10016);
    chk("t3 drain req", 64'(bus_req), 64'd1);
    chk("t3 drain level", 64'(level), 64'd0);
    step(0, 0, 1, 0, 0, 16'h1000);
    chk("t3 new addr", 64'(bus_addr), 64'h10200);
    chk("t3 level", 64'(level), 64'd0);
`ifdef BIU_FLUSH_COUNT_EN
    chk("t3 flush_count", 64'(flush_count), 64'd2);
    chk("t3 discard_count", 64'(discard_count), 64'd1);
`endif

    // IP wrap at the top of the segment.
    step(1, 16'hFFFE, 1, 0, 0, 16'hF000);
    chk("t4 addr fffe", 64'(bus_addr), 64'hFFFFE);
    step(0, 0, 1, 0, 0, 16'hF000);
    chk("t4 addr ffff", 64'(bus_addr), 64'hFFFFF);
    step(0, 0, 1, 0, 0, 16'hF000);
    chk("t4 ip wrap", 64'(fetch_ip), 64'h0000);
    chk("t4 addr wrap", 64'(bus_addr), 64'hF0000);

    // Same-cycle push and pop at level 5.
    repeat (3) step(0, 0, 1, 0, 0, 16'hF000);
    step(0, 0, 1, 1, 2, 16'hF000);
    chk("t5 level", 64'(level), 64'd4);

    // Illegal consumes are ignored.
    step(0, 0, 0, 1, 0, 16'hF000);
    chk("t6 len0", 64'(level), 64'd4);
    step(0, 0, 0, 1, 5, 16'hF000);
    chk("t6 len5", 64'(level), 64'd4);
    step(1, 16'h1234, 0, 0, 0, 16'hF000);
    repeat (3) step(0, 0, 1, 0, 0, 16'hF000);
    step(0, 0, 0, 1, 2, 16'hF000);
    chk("t6 not valid", 64'(level), 64'd2);

    // Randomised traffic.
    cs = 16'h2000;
    for (int n = 0; n < 2000; n++) begin
      bit f;
      f   = ($urandom_range(0, 19) == 0);
      ipl = ($urandom_range(0, 3) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7)))
                                        : 16'($urandom);
      if (f && $urandom_range(0, 1) == 1) cs = 16'($urandom);
      step(f, ipl, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           $urandom_range(0, 7), cs);
    end

    // Reset in the middle of a pending request.
    step(1, 16'h0040, 0, 0, 0, cs);
    reset = 1'b1;
    #1;
    chk("async rst bus_req", 64'(bus_req), 64'd0);
    chk("async rst level", 64'(level), 64'd0);
    chk("async rst fetch_ip", 64'(fetch_ip), 64'd0);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover actual=%0d required=0", exp_q.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
